// File: rtl/line_buffer_3row.sv
// Three-row line buffer feeding the 3x3 Sobel window: column-aligned rows r-2, r-1, r plus edge flag.
// Optional LINE_BUFFER_FRAME_SYNC_EN adds iSOF to resynchronise the frame position.
module line_buffer_3row #(
  parameter int unsigned XWIDTH = 12,
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned CWIDTH = 10,
  parameter int unsigned RWIDTH = 10
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iEN,
`ifdef LINE_BUFFER_FRAME_SYNC_EN
  input  logic              iSOF,
`endif
  input  logic [XWIDTH-1:0] iX,
  output logic [XWIDTH-1:0] oX0,
  output logic [XWIDTH-1:0] oX1,
  output logic [XWIDTH-1:0] oX2,
  output logic              oEN,
  output logic              oEdge
);

  typedef enum logic [1:0] {StFill0, StFill1, StRun} state_e;

  state_e            r_state, w_state, w_state_d;
  logic [CWIDTH-1:0] r_col, w_col, w_col_d;
  logic [RWIDTH-1:0] r_row, w_row, w_row_d;
  logic              w_sof, w_last_col, w_last_row, w_edge;
  logic [XWIDTH-1:0] w_x0, w_x1;

  logic [XWIDTH-1:0] r_buf0 [WIDTH];
  logic [XWIDTH-1:0] r_buf1 [WIDTH];

  // Effective frame position for this cycle; a start-of-frame pixel overrides the counters.
  always_comb begin
`ifdef LINE_BUFFER_FRAME_SYNC_EN
    w_sof = iEN & iSOF;
`else
    w_sof = 1'b0;
`endif
    w_col   = r_col;
    w_row   = r_row;
    w_state = r_state;
    if (w_sof) begin
      w_col   = '0;
      w_row   = '0;
      w_state = StFill0;
    end
    w_last_col = (w_col == CWIDTH'(WIDTH - 1));
    w_last_row = (w_row == RWIDTH'(HEIGHT - 1));
  end

  always_comb begin
    w_col_d   = r_col;
    w_row_d   = r_row;
    w_state_d = r_state;
    if (iEN) begin
      w_col_d   = w_last_col ? '0 : w_col + CWIDTH'(1);
      w_row_d   = w_row;
      w_state_d = w_state;
      if (w_last_col) begin
        if (w_last_row) begin
          w_row_d   = '0;
          w_state_d = StFill0;
        end else begin
          w_row_d = w_row + RWIDTH'(1);
          unique case (w_state)
            StFill0: w_state_d = StFill1;
            StFill1: w_state_d = StRun;
            StRun:   w_state_d = StRun;
            default: w_state_d = StFill0;
          endcase
        end
      end
    end
  end

  // Rows not yet written in this frame are forced to zero, masking stale RAM contents.
  always_comb begin
    w_x1   = (w_state == StFill0) ? '0 : r_buf1[w_col];
    w_x0   = (w_state == StRun) ? r_buf0[w_col] : '0;
    w_edge = (w_state == StRun) && (w_col >= CWIDTH'(2));
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state <= StFill0;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_d;
      r_col   <= w_col_d;
      r_row   <= w_row_d;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oX0   <= '0;
      oX1   <= '0;
      oX2   <= '0;
      oEN   <= 1'b0;
      oEdge <= 1'b0;
    end else begin
      oEN <= iEN;
      if (iEN) begin
        oX0   <= w_x0;
        oX1   <= w_x1;
        oX2   <= iX;
        oEdge <= w_edge;
      end
    end
  end

  // Line RAM: read-before-write shifts the column up one row.
  always_ff @(posedge iCLK) begin
    if (iEN) begin
      r_buf0[w_col] <= r_buf1[w_col];
      r_buf1[w_col] <= iX;
    end
  end

endmodule

// File: tb/tb_line_buffer_3row.sv
// Bench for line_buffer_3row on a 4x4 frame: fixed vector table, corner sequences, and
// random traffic against a frame-image reference model.
module tb_line_buffer_3row;
  localparam int XW = 12;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          iCLK = 1'b0;
  logic          iRST = 1'b1;
  logic          iEN  = 1'b0;
`ifdef LINE_BUFFER_FRAME_SYNC_EN
  logic          iSOF = 1'b0;
`endif
  logic [XW-1:0] iX   = '0;
  logic [XW-1:0] oX0, oX1, oX2;
  logic          oEN, oEdge;

  line_buffer_3row #(
    .XWIDTH(XW), .WIDTH(W), .HEIGHT(H), .CWIDTH(2), .RWIDTH(2)
  ) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .iEN  (iEN),
`ifdef LINE_BUFFER_FRAME_SYNC_EN
    .iSOF (iSOF),
`endif
    .iX   (iX),
    .oX0  (oX0),
    .oX1  (oX1),
    .oX2  (oX2),
    .oEN  (oEN),
    .oEdge(oEdge)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [XW-1:0] x;
    logic [XW-1:0] x0;
    logic [XW-1:0] x1;
    logic [XW-1:0] x2;
    logic          edg;
  } vec_t;
  vec_t tv[16];

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the current frame as an image plus a raster position.
  logic [XW-1:0] img [H][W];
  int            k = 0;
  logic [XW-1:0] m_x0 = '0, m_x1 = '0, m_x2 = '0;
  logic          m_edge = 1'b0, m_en = 1'b0;

  task automatic model_accept(input logic [XW-1:0] x, input logic sof);
    int r, c;
    if (sof) k = 0;
    r = k / W;
    c = k % W;
    m_x2   = x;
    m_x1   = (r >= 1) ? img[r-1][c] : '0;
    m_x0   = (r >= 2) ? img[r-2][c] : '0;
    m_edge = (r >= 2) && (c >= 2) && (r <= H - 1);
    img[r][c] = x;
    k = (k + 1) % (W * H);
  endtask

  task automatic apply(input logic en, input logic [XW-1:0] x, input logic sof);
    iEN = en;
    iX  = x;
`ifdef LINE_BUFFER_FRAME_SYNC_EN
    iSOF = sof;
`endif
    @(posedge iCLK);
    #1;
    m_en = en;
    if (en) model_accept(x, sof);
  endtask

  task automatic check(input string name, input logic [XW-1:0] e0, input logic [XW-1:0] e1,
                       input logic [XW-1:0] e2, input logic eedge, input logic een);
    n_vec++;
    if (oX0 !== e0 || oX1 !== e1 || oX2 !== e2 || oEdge !== eedge || oEN !== een) begin
      n_err++;
      $display("FAIL %s: got x0=%0d x1=%0d x2=%0d edge=%b en=%b, want x0=%0d x1=%0d x2=%0d edge=%b en=%b",
               name, oX0, oX1, oX2, oEdge, oEN, e0, e1, e2, eedge, een);
    end
  endtask

  task automatic check_model(input string name);
    check(name, m_x0, m_x1, m_x2, m_edge, m_en);
  endtask

  // Called just after a clock edge: asserts reset, checks the cleared outputs, releases it.
  task automatic do_reset();
    iRST = 1'b0;
    #1;
    k = 0;
    m_x0 = '0; m_x1 = '0; m_x2 = '0; m_edge = 1'b0; m_en = 1'b0;
    check("reset", '0, '0, '0, 1'b0, 1'b0);
    #1;
    iRST = 1'b1;
  endtask

  task automatic set_tv(input int i, input int x0, input int x1, input int x2, input logic e);
    tv[i].x = XW'(i + 1); tv[i].x0 = XW'(x0); tv[i].x1 = XW'(x1); tv[i].x2 = XW'(x2);
    tv[i].edg = e;
  endtask

  initial begin
    set_tv(0, 0, 0, 1, 0);   set_tv(1, 0, 0, 2, 0);   set_tv(2, 0, 0, 3, 0);   set_tv(3, 0, 0, 4, 0);
    set_tv(4, 0, 1, 5, 0);   set_tv(5, 0, 2, 6, 0);   set_tv(6, 0, 3, 7, 0);   set_tv(7, 0, 4, 8, 0);
    set_tv(8, 1, 5, 9, 0);   set_tv(9, 2, 6, 10, 0);  set_tv(10, 3, 7, 11, 1); set_tv(11, 4, 8, 12, 1);
    set_tv(12, 5, 9, 13, 0); set_tv(13, 6, 10, 14, 0); set_tv(14, 7, 11, 15, 1);
    set_tv(15, 8, 12, 16, 1);

    @(posedge iCLK);
    #1;
    do_reset();

    // Frame 1, continuous valid.
    for (int i = 0; i < 16; i++) begin
      apply(1'b1, tv[i].x, 1'b0);
      check("frame1", tv[i].x0, tv[i].x1, tv[i].x2, tv[i].edg, 1'b1);
    end

    // Frame 2 back-to-back: first row must be back in FILL0.
    for (int i = 0; i < 16; i++) begin
      apply(1'b1, XW'(17 + i), 1'b0);
      check_model("frame2");
      if (i == 0) check("px17_fill0", '0, '0, 12'd17, 1'b0, 1'b1);
      if (i == 8) check("px25", 12'd17, 12'd21, 12'd25, 1'b0, 1'b1);
    end

    // Frame 3 with a gap after every pixel: outputs hold, oEN drops.
    for (int i = 0; i < 16; i++) begin
      apply(1'b1, tv[i].x, 1'b0);
      check("gap_valid", tv[i].x0, tv[i].x1, tv[i].x2, tv[i].edg, 1'b1);
      apply(1'b0, XW'($urandom_range(0, 4095)), 1'b0);
      check("gap_hold", tv[i].x0, tv[i].x1, tv[i].x2, tv[i].edg, 1'b0);
    end

    // Reset after pixel 10, then a fresh pixel lands in FILL0.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, XW'(i + 1), 1'b0);
      check_model("pre_reset");
    end
    do_reset();
    apply(1'b1, 12'd99, 1'b0);
    check("after_reset", '0, '0, 12'd99, 1'b0, 1'b1);

`ifdef LINE_BUFFER_FRAME_SYNC_EN
    do_reset();
    for (int i = 0; i < 9; i++) begin
      apply(1'b1, XW'(i + 1), 1'b0);
      check_model("pre_sof");
    end
    apply(1'b1, 12'd7, 1'b1);
    check("sof", '0, '0, 12'd7, 1'b0, 1'b1);
    apply(1'b0, 12'd0, 1'b1);
    check("sof_idle", '0, '0, 12'd7, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      apply(1'b1, XW'(40 + i), 1'b0);
      check_model("post_sof");
    end
`endif

    // Random traffic with occasional mid-frame reset.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic en, sof;
      en  = ($urandom_range(0, 3) != 0);
      sof = 1'b0;
`ifdef LINE_BUFFER_FRAME_SYNC_EN
      sof = ($urandom_range(0, 30) == 0);
`endif
      apply(en, XW'($urandom_range(0, 4095)), sof);
      check_model("random");
      if ($urandom_range(0, 60) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
